mic_frame_player: RTL and testbench
===================================

Name: mic_frame_player

Overview:
- Synthesizable, parametrised multi-channel sample playback engine. It replaces bench-only memory stimulus feeding the XCORR path.
- Holds one frame per channel in internal sync RAM, loaded through a write port.
- Streams frames out as a parallel CH-wide sample word with valid/ready, start-of-frame and end-of-frame markers.
- Supports single-shot, loop and abort/restart. Sits between the loader (host/UART/test logic) and the MIC_SUBSYS XCORR inputs.

Parameters:
- W, 16, sample width (signed two's complement)
- CH, 2, channel count (XCORR pair = 2; arrays up to 8)
- DEPTH, 512, samples per channel frame; power of two
- AW, 9, address width = log2(DEPTH)
- PAD_LEN, 64, zero samples appended per frame (used only with PLAYER_ZERO_PAD_EN)

Ports:
- clk  in  1  system clock (clk_60MHz domain)
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  RAM write strobe
- wr_ch  in  max(1,clog2(CH))  channel select for write
- wr_addr  in  AW  write address
- wr_data  in  W  write sample
- start_i  in  1  single-cycle start/restart pulse
- stop_i  in  1  abort request
- loop_en  in  1  replay frame continuously
- frame_len  in  AW+1  samples per frame; sampled at start
- ready_i  in  1  downstream accepts beat
- series_o  out  CH*W  channel c at bits [c*W +: W]
- valid_o  out  1  beat valid
- sof_o  out  1  first beat of frame
- eof_o  out  1  last data beat of frame
- busy_o  out  1  FSM not IDLE
- done_o  out  1  one-cycle pulse when a non-looping frame completes
- frame_cnt_o  out  16  frames completed since start, wraps at 65535->0

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0. Reset mid-operation aborts instantly; RAM contents are undefined and not cleared.
- frame_len latched on start_i. A value of 0 or >DEPTH is treated as DEPTH.
- FSM states:
  - IDLE: start_i -> PRIME.
  - PRIME: issues RAM read of addr 0. Next cycle -> RUN.
  - RUN: streams beats.
  - PAD: only with the optional feature.
- Latency: start_i at cycle T -> valid_o=1 with sof_o=1 at T+2 (assuming valid_o held by ready_i=0 does not apply at start).
- Handshake:
  - A beat transfers when valid_o && ready_i.
  - While valid_o=1 && ready_i=0, series_o/sof_o/eof_o are held stable.
  - The address advances only on transfer. A prefetch register hides the RAM latency, so back-to-back transfers are possible at 1 beat/cycle.
- eof_o is asserted on beat index frame_len-1. On transfer of the eof beat:
  - If loop_en=1, the next beat is addr 0 with sof_o=1, no bubble, and frame_cnt_o increments.
  - Otherwise -> IDLE, done_o pulses the next cycle, frame_cnt_o increments, valid_o drops.
- Boundary cases:
  - frame_len=1: sof_o and eof_o are asserted on the same beat.
  - start_i while busy: abort and restart from addr 0 via PRIME. frame_cnt_o is cleared. No done_o pulse.
  - stop_i: valid_o drops next cycle and FSM -> IDLE; no done_o. stop_i and start_i in the same cycle -> start_i wins.
  - Write to an address being read in the same cycle: the read returns the old data.
  - Writes are allowed in any state.
  - wr_ch >= CH: write ignored.
- Arithmetic: no sign manipulation. Samples pass bit-exact.

Optional Feature:
- Macro PLAYER_ZERO_PAD_EN.
- Defined:
  - After the eof beat transfers, the FSM enters PAD and emits PAD_LEN beats of series_o=0 with valid_o=1, sof_o=0, eof_o=0, under the same handshake.
  - Then it loops (to sof) or finishes (done_o, IDLE) as above.
  - frame_cnt_o increments at the end of PAD.
- Undefined: no PAD state; PAD_LEN is ignored; behaviour exactly as in Behaviour.

Test Plan:
- Load ch0[i]=i, ch1[i]=-i for i=0..511; frame_len=512; loop_en=0; ready_i=1; pulse start_i -> 512 beats on consecutive cycles, first at T+2 with sof_o. Beat k has ch0=k, ch1=-k. eof_o on k=511. done_o one cycle later; frame_cnt_o=1.
- Same load; ready_i random 50% -> the captured sequence is identical to the previous case. series_o is stable whenever valid_o && !ready_i.
- frame_len=4, loop_en=1, run 3 frames -> ch0 sequence 0,1,2,3,0,1,2,3,0,1,2,3 with sof_o every 4th beat and no gaps. frame_cnt_o=3; no done_o.
- frame_len=0 and frame_len=1 -> 512 beats; single beat with sof_o=eof_o=1.
- start_i at beat 100, then stop_i at beat 50 of the restarted frame, then rst_n low mid-frame:
  - Restart resumes at ch0=0 with sof_o; frame_cnt_o is cleared.
  - stop_i drops valid_o next cycle with no done_o.
  - Reset zeroes all outputs asynchronously.
- With PLAYER_ZERO_PAD_EN, frame_len=8, PAD_LEN=4 -> 8 data beats then 4 zero beats. done_o after the last zero beat; frame_cnt_o=1.

Source files
------------

// File: rtl/mic_frame_player.sv
// Multi-channel frame playback engine: per-channel sync RAM loaded by a write port, streamed out
// as a CH-wide sample word with valid/ready, sof/eof. Optional zero padding via PLAYER_ZERO_PAD_EN.
module mic_frame_player #(
  parameter int W       = 16,
  parameter int CH      = 2,
  parameter int DEPTH   = 512,
  parameter int AW      = 9,
  parameter int PAD_LEN = 64,
  localparam int CW     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_ch,
  input  logic [AW-1:0]     wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_en,
  input  logic [AW:0]       frame_len,
  input  logic              ready_i,
  output logic [CH*W-1:0]   series_o,
  output logic              valid_o,
  output logic              sof_o,
  output logic              eof_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       frame_cnt_o
);

  if (DEPTH != (1 << AW) || CH < 1 || PAD_LEN < 1) begin : g_bad_cfg
    $error("mic_frame_player: DEPTH must equal 2**AW, CH and PAD_LEN must be >= 1");
  end

`ifdef PLAYER_ZERO_PAD_EN
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_PAD} state_e;
  localparam int PW = (PAD_LEN > 1) ? $clog2(PAD_LEN) : 1;
  logic [PW-1:0] pad_q, pad_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_e;
`endif

  state_e        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] beat_q, beat_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          done_q, done_d;

  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   eff_len;
  logic          last_beat;
  logic          xfer;

  // Zero and anything beyond the RAM both mean "play the whole frame".
  assign eff_len   = (frame_len == '0 || frame_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : frame_len;
  assign last_beat = ({1'b0, beat_q} == len_q - 1'b1);
  assign xfer      = valid_o && ready_i;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    rd_en   = 1'b0;
    rd_addr = beat_q + 1'b1;
`ifdef PLAYER_ZERO_PAD_EN
    pad_d   = pad_q;
`endif
    if (start_i) begin
      state_d = S_PRIME;
      len_d   = eff_len;
      beat_d  = '0;
      cnt_d   = '0;
`ifdef PLAYER_ZERO_PAD_EN
      pad_d   = '0;
`endif
    end else if (stop_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_PRIME: begin
          rd_en   = 1'b1;
          rd_addr = '0;
          beat_d  = '0;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (xfer) begin
            if (!last_beat) begin
              rd_en  = 1'b1;
              beat_d = beat_q + 1'b1;
            end else begin
`ifdef PLAYER_ZERO_PAD_EN
              state_d = S_PAD;
              pad_d   = '0;
`else
              cnt_d = cnt_q + 16'd1;
              if (loop_en) begin
                rd_en   = 1'b1;
                rd_addr = '0;
                beat_d  = '0;
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
`endif
            end
          end
        end
`ifdef PLAYER_ZERO_PAD_EN
        S_PAD: begin
          if (xfer) begin
            if (pad_q == PW'(PAD_LEN - 1)) begin
              cnt_d = cnt_q + 16'd1;
              if (loop_en) begin
                rd_en   = 1'b1;
                rd_addr = '0;
                beat_d  = '0;
                state_d = S_RUN;
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              pad_d = pad_q + 1'b1;
            end
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef PLAYER_ZERO_PAD_EN
      pad_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef PLAYER_ZERO_PAD_EN
      pad_q   <= pad_d;
`endif
    end
  end

  // The RAM read register doubles as the output holding register: it only reloads on a
  // transfer (or in PRIME), so a stalled beat stays put and a same-address write is not seen.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_q;

    // NOTE: the sample RAM and its read register carry no reset; contents are don't-care
    // until loaded and the output is gated off outside RUN.
    always_ff @(posedge clk) begin
      if (wr_en && wr_ch == CW'(c)) mem[wr_addr] <= wr_data;
      if (rd_en) rd_q <= mem[rd_addr];
    end

    assign series_o[c*W +: W] = (state_q == S_RUN) ? rd_q : '0;
  end

`ifdef PLAYER_ZERO_PAD_EN
  assign valid_o = (state_q == S_RUN) || (state_q == S_PAD);
`else
  assign valid_o = (state_q == S_RUN);
`endif
  assign sof_o       = (state_q == S_RUN) && (beat_q == '0);
  assign eof_o       = (state_q == S_RUN) && last_beat;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_mic_frame_player.sv
// Directed bench for mic_frame_player: scoreboard of expected beats built from a shadow copy
// of the written RAM, compared on every valid&&ready transfer.
module tb_mic_frame_player;
  localparam int W = 16, CH = 2, DEPTH = 512, AW = 9, PAD_LEN = 4, CW = 1;
`ifdef PLAYER_ZERO_PAD_EN
  localparam int PADB = PAD_LEN;
`else
  localparam int PADB = 0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic [CW-1:0] wr_ch = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic start_i = 1'b0, stop_i = 1'b0, loop_en = 1'b0, ready_i = 1'b0;
  logic [AW:0] frame_len = '0;
  logic [CH*W-1:0] series_o;
  logic valid_o, sof_o, eof_o, busy_o, done_o;
  logic [15:0] frame_cnt_o;

  mic_frame_player #(.W(W), .CH(CH), .DEPTH(DEPTH), .AW(AW), .PAD_LEN(PAD_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
    .wr_data(wr_data), .start_i(start_i), .stop_i(stop_i), .loop_en(loop_en),
    .frame_len(frame_len), .ready_i(ready_i), .series_o(series_o), .valid_o(valid_o),
    .sof_o(sof_o), .eof_o(eof_o), .busy_o(busy_o), .done_o(done_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  logic [W-1:0] model [CH][DEPTH];
  logic [CH*W+1:0] sb_q [$];
  int checks = 0, errors = 0;
  int got, cyc;
  bit saw_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input int c, input int a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_ch = CW'(c); wr_addr = AW'(a); wr_data = d;
    model[c][a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push_frame(input int len);
    int eff;
    logic [CH*W-1:0] word;
    eff = (len == 0 || len > DEPTH) ? DEPTH : len;
    for (int k = 0; k < eff; k++) begin
      for (int c = 0; c < CH; c++) word[c*W +: W] = model[c][k];
      sb_q.push_back({k == 0, k == eff - 1, word});
    end
    for (int p = 0; p < PADB; p++) sb_q.push_back('0);
  endtask

  // Pulse start at the current negedge; checks PRIME cycle then first beat at T+2.
  task automatic start_frame(input int len, input bit loop);
    frame_len = (AW+1)'(len); loop_en = loop; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("prime_state", 64'({valid_o, busy_o, frame_cnt_o}), 64'({1'b0, 1'b1, 16'd0}));
    @(negedge clk);
    check("first_beat_sof", 64'({valid_o, sof_o}), 64'(2'b11));
  endtask

  task automatic stream(input int n, input bit rnd);
    logic [CH*W+1:0] snap, obs;
    bit held;
    got = 0; cyc = 0; saw_done = 1'b0; held = 1'b0; snap = '0;
    while (got < n && cyc < 4000) begin
      obs = {sof_o, eof_o, series_o};
      if (held) begin
        check("hold_valid", 64'(valid_o), 64'(1));
        check("hold_data", 64'(obs), 64'(snap));
      end
      if (done_o) saw_done = 1'b1;
      ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      held = 1'b0;
      if (valid_o && ready_i) begin
        if (sb_q.size() == 0) check("sb_underflow", 64'(sb_q.size()), 64'(1));
        else check("beat", 64'(obs), 64'(sb_q.pop_front()));
        got++;
      end else if (valid_o) begin
        held = 1'b1;
        snap = obs;
      end
      @(negedge clk);
      cyc++;
    end
    check("stream_count", 64'(got), 64'(n));
  endtask

  task automatic end_of_frame(input int exp_cnt);
    check("no_early_done", 64'(saw_done), 64'(0));
    check("done_idle", 64'({done_o, valid_o, busy_o}), 64'(3'b100));
    check("frame_cnt", 64'(frame_cnt_o), 64'(exp_cnt));
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    @(negedge clk);
    check("done_pulse_len", 64'(done_o), 64'(0));
  endtask

  initial begin
    #2;
    check("rst_outputs", 64'({series_o, valid_o, sof_o, eof_o, busy_o, done_o}), 64'(0));
    check("rst_frame_cnt", 64'(frame_cnt_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) begin
      write_word(0, i, W'(i));
      write_word(1, i, W'(-i));
    end

    // Full frame, downstream always ready: gapless, done and count after the last beat.
    ready_i = 1'b1;
    push_frame(512);
    start_frame(512, 1'b0);
    stream(512 + PADB, 1'b0);
    check("gapless_512", 64'(cyc), 64'(512 + PADB));
    end_of_frame(1);

    // Same frame with random backpressure.
    ready_i = 1'b0;
    push_frame(512);
    start_frame(512, 1'b0);
    stream(512 + PADB, 1'b1);
    end_of_frame(1);

    // Looping 4-beat frame, three passes back to back.
    ready_i = 1'b1;
    for (int f = 0; f < 3; f++) push_frame(4);
    start_frame(4, 1'b1);
    stream(3 * (4 + PADB), 1'b0);
    check("loop_gapless", 64'(cyc), 64'(3 * (4 + PADB)));
    check("loop_no_done", 64'(saw_done), 64'(0));
    check("loop_cnt3", 64'({valid_o, sof_o, frame_cnt_o}), 64'({1'b1, 1'b1, 16'd3}));

    // Restart while looping clears the frame count and starts over at sof.
    push_frame(4);
    start_frame(4, 1'b1);
    stream(4 + PADB, 1'b0);
    check("restart_cnt1", 64'(frame_cnt_o), 64'(1));
    ready_i = 1'b0; stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check("stop_idle", 64'({valid_o, busy_o, done_o}), 64'(0));
    @(negedge clk);
    check("stop_no_done", 64'(done_o), 64'(0));
    check("stop_keeps_cnt", 64'(frame_cnt_o), 64'(1));

    // Length 0 and oversize both play the full RAM.
    ready_i = 1'b1;
    push_frame(0);
    start_frame(0, 1'b0);
    stream(512 + PADB, 1'b0);
    end_of_frame(1);
    push_frame(700);
    start_frame(700, 1'b0);
    stream(512 + PADB, 1'b0);
    end_of_frame(1);

    // Single-beat frame: sof and eof together.
    write_word(0, 0, 16'h1234);
    write_word(1, 0, 16'hABCD);
    push_frame(1);
    start_frame(1, 1'b0);
    check("len1_sof_eof", 64'({sof_o, eof_o, series_o}), 64'({2'b11, 16'hABCD, 16'h1234}));
    stream(1 + PADB, 1'b0);
    end_of_frame(1);
    write_word(0, 0, 16'h0000);
    write_word(1, 0, 16'h0000);

    // Abort at beat 100, then stop at beat 50 of the restarted frame.
    push_frame(512);
    start_frame(512, 1'b0);
    stream(100, 1'b0);
    sb_q.delete();
    push_frame(512);
    start_frame(512, 1'b0);
    check("restart_beat0", 64'(series_o), 64'(0));
    stream(50, 1'b0);
    sb_q.delete();
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check("abort_stop_idle", 64'({valid_o, busy_o, done_o}), 64'(0));
    @(negedge clk);
    check("abort_no_done", 64'(done_o), 64'(0));

    // start and stop together: start wins.
    push_frame(512);
    frame_len = 10'd512; loop_en = 1'b0;
    start_i = 1'b1; stop_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0;
    check("start_beats_stop", 64'({valid_o, busy_o}), 64'(2'b01));
    @(negedge clk);
    check("start_beats_stop_sof", 64'({valid_o, sof_o}), 64'(2'b11));
    stream(20, 1'b0);

    // Asynchronous reset mid-frame, checked between clock edges.
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 64'({series_o, valid_o, sof_o, eof_o, busy_o, done_o}), 64'(0));
    check("async_rst_cnt", 64'(frame_cnt_o), 64'(0));
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
